// File: rtl/nco_multich_if.sv
`default_nettype none
// =====================================================================
// Module   : nco_multich_if
// Brief    : AXI-stream sample bus carrying {sin, cos}, channel and last.
// Revision : 1.0 - initial release
// =====================================================================
interface nco_multich_if #(
  parameter int OUT_DW = 16,
  parameter int CH_W   = 2
);
  logic [2*OUT_DW-1:0] tdata;
  logic [CH_W-1:0]     tuser;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/nco_multich.sv
`default_nettype none
// =====================================================================
// Module   : nco_multich
// Brief    : Time-multiplexed multi-channel NCO, quarter-wave sin/cos LUT,
//            AXI-stream output with backpressure.
// Revision : 1.0 - initial release
// =====================================================================
module nco_multich #(
  parameter int PHASE_DW = 16,
  parameter int OUT_DW   = 16,
  parameter int LUT_AW   = 14,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PHASE_DW-1:0] cfg_ftw,
  input  logic [PHASE_DW-1:0] cfg_poff,
  input  logic                sync,
  nco_multich_if.master       m_axis
);

  localparam int  c_depth = 1 << LUT_AW;
  localparam real c_pi    = 3.14159265358979323846;
  localparam real c_amp   = $itor((1 << (OUT_DW - 1)) - 1);
  localparam real c_step  = 2.0 * c_pi / $itor(4 * c_depth);
  localparam logic [OUT_DW-2:0] c_peak = '1;
  localparam logic [CH_W-1:0]   c_last_ch = CH_W'(NUM_CH - 1);

  if (LUT_AW < 2 || LUT_AW > PHASE_DW - 2) begin : g_bad_lut_aw
    $error("nco_multich: LUT_AW must lie in 2..PHASE_DW-2");
  end
  if (NUM_CH < 1 || NUM_CH > 64) begin : g_bad_num_ch
    $error("nco_multich: NUM_CH must lie in 1..64");
  end

  function automatic logic [OUT_DW-2:0] f_rom(input int i);
    return (OUT_DW-1)'($rtoi(c_amp * $sin(c_step * $itor(i)) + 0.5));
  endfunction

  // Quarter-wave ROM; entries are elaboration-time constants
  logic [OUT_DW-2:0] w_rom [c_depth];
  for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
    localparam logic [OUT_DW-2:0] c_val = f_rom(gi);
    assign w_rom[gi] = c_val;
  end

  logic [PHASE_DW-1:0] r_acc  [NUM_CH];
  logic [PHASE_DW-1:0] r_ftw  [NUM_CH];
  logic [PHASE_DW-1:0] r_poff [NUM_CH];
  logic [CH_W-1:0]     r_ch_cnt;

  logic                w_adv;
  logic                w_issue;
  logic [PHASE_DW-1:0] w_phase;

  assign w_adv   = !m_axis.tvalid || m_axis.tready;
  assign w_issue = w_adv && en;
  assign w_phase = r_acc[r_ch_cnt] + r_poff[r_ch_cnt];

  // Config lands after the issue read, and sync overrides the accumulator step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c]  <= '0;
        r_ftw[c]  <= '0;
        r_poff[c] <= '0;
      end
      r_ch_cnt <= '0;
    end else begin
      if (w_issue) begin
        r_acc[r_ch_cnt] <= r_acc[r_ch_cnt] + r_ftw[r_ch_cnt];
        r_ch_cnt        <= (r_ch_cnt == c_last_ch) ? '0 : r_ch_cnt + 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_valid && cfg_ch == CH_W'(c)) begin
          r_ftw[c]  <= cfg_ftw;
          r_poff[c] <= cfg_poff;
        end
      end
      if (sync) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_acc[c] <= '0;
        end
        r_ch_cnt <= '0;
      end
    end
  end

  logic                r_s1_v;
  logic [PHASE_DW-1:0] r_s1_phase;
  logic [CH_W-1:0]     r_s1_ch;

  logic                r_s2_v;
  logic [1:0]          r_s2_q;
  logic [LUT_AW-1:0]   r_s2_sin_a;
  logic [LUT_AW-1:0]   r_s2_cos_a;
  logic                r_s2_zero;
  logic [CH_W-1:0]     r_s2_ch;

  logic                r_s3_v;
  logic [1:0]          r_s3_q;
  logic [OUT_DW-2:0]   r_s3_sin_m;
  logic [OUT_DW-2:0]   r_s3_cos_m;
  logic                r_s3_zero;
  logic [CH_W-1:0]     r_s3_ch;

  logic                r_s4_v;
  logic [OUT_DW-1:0]   r_s4_sin;
  logic [OUT_DW-1:0]   r_s4_cos;
  logic [CH_W-1:0]     r_s4_ch;

  logic [1:0]          w_q;
  logic [LUT_AW-1:0]   w_idx;
  logic [LUT_AW-1:0]   w_idx_neg;
  logic [OUT_DW-1:0]   w_sin_mag;
  logic [OUT_DW-1:0]   w_cos_mag;
  logic [OUT_DW-1:0]   w_sin_val;
  logic [OUT_DW-1:0]   w_cos_val;

  assign w_q       = r_s1_phase[PHASE_DW-1 -: 2];
  assign w_idx     = r_s1_phase[PHASE_DW-3 -: LUT_AW];
  assign w_idx_neg = -w_idx;

  // idx==0 on the mirrored port points past the table end, i.e. at full scale
  assign w_sin_mag = {1'b0, (r_s3_q[0] && r_s3_zero)  ? c_peak : r_s3_sin_m};
  assign w_cos_mag = {1'b0, (!r_s3_q[0] && r_s3_zero) ? c_peak : r_s3_cos_m};
  assign w_sin_val = r_s3_q[1] ? -w_sin_mag : w_sin_mag;
  assign w_cos_val = (r_s3_q[1] ^ r_s3_q[0]) ? -w_cos_mag : w_cos_mag;

  // Payload registers only load with valid data so bubbles leave them untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v        <= 1'b0;
      r_s1_phase    <= '0;
      r_s1_ch       <= '0;
      r_s2_v        <= 1'b0;
      r_s2_q        <= '0;
      r_s2_sin_a    <= '0;
      r_s2_cos_a    <= '0;
      r_s2_zero     <= 1'b0;
      r_s2_ch       <= '0;
      r_s3_v        <= 1'b0;
      r_s3_q        <= '0;
      r_s3_sin_m    <= '0;
      r_s3_cos_m    <= '0;
      r_s3_zero     <= 1'b0;
      r_s3_ch       <= '0;
      r_s4_v        <= 1'b0;
      r_s4_sin      <= '0;
      r_s4_cos      <= '0;
      r_s4_ch       <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tuser  <= '0;
      m_axis.tlast  <= 1'b0;
    end else if (w_adv) begin
      r_s1_v <= en;
      if (en) begin
        r_s1_phase <= w_phase;
        r_s1_ch    <= r_ch_cnt;
      end

      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_q     <= w_q;
        r_s2_sin_a <= w_q[0] ? w_idx_neg : w_idx;
        r_s2_cos_a <= w_q[0] ? w_idx : w_idx_neg;
        r_s2_zero  <= (w_idx == '0);
        r_s2_ch    <= r_s1_ch;
      end

      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_s3_q     <= r_s2_q;
        r_s3_sin_m <= w_rom[r_s2_sin_a];
        r_s3_cos_m <= w_rom[r_s2_cos_a];
        r_s3_zero  <= r_s2_zero;
        r_s3_ch    <= r_s2_ch;
      end

      r_s4_v <= r_s3_v;
      if (r_s3_v) begin
        r_s4_sin <= w_sin_val;
        r_s4_cos <= w_cos_val;
        r_s4_ch  <= r_s3_ch;
      end

      m_axis.tvalid <= r_s4_v;
      if (r_s4_v) begin
        m_axis.tdata <= {r_s4_sin, r_s4_cos};
        m_axis.tuser <= r_s4_ch;
        m_axis.tlast <= (r_s4_ch == c_last_ch);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_multich.sv
`default_nettype none
// =====================================================================
// Module   : tb_nco_multich
// Brief    : Directed/self-checking bench for nco_multich against a
//            sin/cos reference model with latency/backpressure tracking.
// Revision : 1.0 - initial release
// =====================================================================
module tb_nco_multich;

  localparam int PHASE_DW = 16;
  localparam int OUT_DW   = 16;
  localparam int LUT_AW   = 14;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int SHIFT    = PHASE_DW - LUT_AW - 2;

  logic                clk       = 1'b0;
  logic                reset     = 1'b1;
  logic                en        = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [CH_W-1:0]     cfg_ch    = '0;
  logic [PHASE_DW-1:0] cfg_ftw   = '0;
  logic [PHASE_DW-1:0] cfg_poff  = '0;
  logic                sync      = 1'b0;

  nco_multich_if #(.OUT_DW(OUT_DW), .CH_W(CH_W)) axis ();

  nco_multich #(
    .PHASE_DW(PHASE_DW), .OUT_DW(OUT_DW), .LUT_AW(LUT_AW),
    .NUM_CH(NUM_CH), .CH_W(CH_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_ftw  (cfg_ftw),
    .cfg_poff (cfg_poff),
    .sync     (sync),
    .m_axis   (axis)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Ideal full-wave sample of the truncated phase
  function automatic logic [2*OUT_DW-1:0] model_iq(input logic [PHASE_DW-1:0] ph);
    real amp, ang;
    int  k, s, c;
    amp = $itor((1 << (OUT_DW - 1)) - 1);
    k   = int'(ph >> SHIFT);
    ang = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(1 << (LUT_AW + 2));
    s   = rnd(amp * $sin(ang));
    c   = rnd(amp * $cos(ang));
    return {s[OUT_DW-1:0], c[OUT_DW-1:0]};
  endfunction

  typedef struct {
    bit                  v;
    logic [2*OUT_DW-1:0] d;
    int                  ch;
  } slot_t;

  typedef struct {
    logic [2*OUT_DW-1:0] d;
    logic [CH_W-1:0]     u;
    logic                l;
  } xfer_t;

  slot_t               slots [5];
  logic [PHASE_DW-1:0] m_acc  [NUM_CH];
  logic [PHASE_DW-1:0] m_ftw  [NUM_CH];
  logic [PHASE_DW-1:0] m_poff [NUM_CH];
  int                  m_ch;
  xfer_t               got [$];

  task automatic model_clear();
    for (int i = 0; i < 5; i++) slots[i] = '{1'b0, '0, 0};
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c] = '0; m_ftw[c] = '0; m_poff[c] = '0;
    end
    m_ch = 0;
  endtask

  task automatic model_step();
    logic [PHASE_DW-1:0] ph;
    bit adv;
    if (reset) begin
      model_clear();
      return;
    end
    adv = !slots[4].v || axis.tready;
    if (adv) begin
      for (int i = 4; i > 0; i--) slots[i] = slots[i-1];
      slots[0] = '{1'b0, '0, 0};
      if (en) begin
        ph       = m_acc[m_ch] + m_poff[m_ch];
        slots[0] = '{1'b1, model_iq(ph), m_ch};
        m_acc[m_ch] = m_acc[m_ch] + m_ftw[m_ch];
        m_ch = (m_ch + 1) % NUM_CH;
      end
    end
    if (cfg_valid && int'(cfg_ch) < NUM_CH) begin
      m_ftw[cfg_ch]  = cfg_ftw;
      m_poff[cfg_ch] = cfg_poff;
    end
    if (sync) begin
      for (int c = 0; c < NUM_CH; c++) m_acc[c] = '0;
      m_ch = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  bit                  prev_stall = 1'b0;
  logic [2*OUT_DW+CH_W:0] prev_out = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_outputs", 64'({axis.tvalid, axis.tlast, axis.tuser, axis.tdata}), 64'(0));
      end else begin
        check("tvalid", 64'(axis.tvalid), 64'(slots[4].v));
        if (slots[4].v) begin
          check("tdata", 64'(axis.tdata), 64'(slots[4].d));
          check("tuser", 64'(axis.tuser), 64'(slots[4].ch));
          check("tlast", 64'(axis.tlast), 64'(slots[4].ch == NUM_CH - 1));
        end
        if (prev_stall)
          check("stall_hold", 64'({axis.tvalid, axis.tlast, axis.tuser, axis.tdata}), 64'({1'b1, prev_out}));
        if (axis.tvalid && axis.tready)
          got.push_back('{axis.tdata, axis.tuser, axis.tlast});
      end
      prev_stall = !reset && axis.tvalid && !axis.tready;
      prev_out   = {axis.tlast, axis.tuser, axis.tdata};
    end
  end

  task automatic cfg_write(input int ch, input int ftw, input int poff);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_ftw   = PHASE_DW'(ftw);
    cfg_poff  = PHASE_DW'(poff);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int cfg_f [NUM_CH] = '{32'h4000, 32'h0000, 32'hC000, 32'h0000};
  int cfg_p [NUM_CH] = '{32'h0000, 32'h2000, 32'h0000, 32'h0000};
  logic [2*OUT_DW-1:0] tbl [16] = '{
    32'h0000_7FFF, 32'h5A82_5A82, 32'h0000_7FFF, 32'h0000_7FFF,
    32'h7FFF_0000, 32'h5A82_5A82, 32'h8001_0000, 32'h0000_7FFF,
    32'h0000_8001, 32'h5A82_5A82, 32'h0000_8001, 32'h0000_7FFF,
    32'h8001_0000, 32'h5A82_5A82, 32'h7FFF_0000, 32'h0000_7FFF};
  int target;
  int budget;
  int pulse;

  initial begin
    axis.tready = 1'b1;
    cycles(3);
    check("rst_tvalid", 64'(axis.tvalid), 64'(0));
    check("rst_tdata", 64'(axis.tdata), 64'(0));
    check("model_q1", 64'(model_iq(16'h4000)), 64'(32'h7FFF_0000));
    check("model_45", 64'(model_iq(16'h2000)), 64'(32'h5A82_5A82));
    check("model_q2", 64'(model_iq(16'h8000)), 64'(32'h0000_8001));
    check("model_q3", 64'(model_iq(16'hC000)), 64'(32'h8001_0000));
    reset = 1'b0;

    // Basic streams: quadrant walk, constant 45 degrees, negative step
    for (int c = 0; c < NUM_CH; c++) cfg_write(c, cfg_f[c], cfg_p[c]);
    got.delete();
    en = 1'b1;
    cycles(24);
    check("t1_count", 64'(got.size() >= 16), 64'(1));
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      check("t1_data", 64'(got[k].d), 64'(tbl[k]));
      check("t1_user", 64'(got[k].u), 64'(k % NUM_CH));
      check("t1_last", 64'(got[k].l), 64'(k % NUM_CH == NUM_CH - 1));
    end

    // Drain, resync, then stream under random backpressure and en gaps
    en = 1'b0;
    cycles(8);
    sync = 1'b1;
    cycles(1);
    sync = 1'b0;
    got.delete();
    target = 1000;
    budget = 0;
    pulse  = 0;
    while (got.size() < target && budget < 20000) begin
      if (pulse > 0) begin
        axis.tready = 1'b0;
        pulse--;
      end else if ($urandom_range(0, 15) == 0) begin
        axis.tready = 1'b0;
        pulse = 4;
      end else begin
        axis.tready = ($urandom_range(0, 3) != 0);
      end
      en = ($urandom_range(0, 9) != 0);
      cycles(1);
      budget++;
    end
    check("t2_timeout", 64'(got.size() >= target), 64'(1));
    for (int k = 0; k < target && k < got.size(); k++) begin
      check("t2_golden", 64'({got[k].u, got[k].d}),
            64'({CH_W'(k % NUM_CH),
                 model_iq(PHASE_DW'(cfg_p[k % NUM_CH] + (k / NUM_CH) * cfg_f[k % NUM_CH]))}));
    end

    // Config write on the issue cycle of channel 0, then sync mid-stream
    en = 1'b1;
    axis.tready = 1'b1;
    for (int i = 0; i < 8 && m_ch != 0; i++) cycles(1);
    check("t3_align", 64'(m_ch), 64'(0));
    cfg_write(0, 32'h1000, 32'h4000);
    cycles(6);
    sync = 1'b1;
    cycles(1);
    sync = 1'b0;
    cycles(5);
    check("t3_sync_valid", 64'(axis.tvalid), 64'(1));
    check("t3_sync_user", 64'(axis.tuser), 64'(0));
    check("t3_sync_data", 64'(axis.tdata), 64'(32'h7FFF_0000));

    // Sync plus config together while stalled
    axis.tready = 1'b0;
    cycles(3);
    sync = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_ftw = 16'h0800; cfg_poff = 16'h1000;
    cycles(1);
    sync = 1'b0;
    cfg_valid = 1'b0;
    cycles(3);
    axis.tready = 1'b1;
    cycles(20);

    // One-cycle reset mid-stream
    reset = 1'b1;
    #1;
    check("t4_rst_tvalid", 64'(axis.tvalid), 64'(0));
    check("t4_rst_out", 64'({axis.tlast, axis.tuser, axis.tdata}), 64'(0));
    cycles(1);
    reset = 1'b0;
    cycles(4);
    check("t4_pre_tvalid", 64'(axis.tvalid), 64'(0));
    check("t4_pre_tdata", 64'(axis.tdata), 64'(0));
    cycles(1);
    check("t4_first_valid", 64'(axis.tvalid), 64'(1));
    check("t4_first_user", 64'(axis.tuser), 64'(0));
    check("t4_first_data", 64'(axis.tdata), 64'(32'h0000_7FFF));
    cycles(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
